// File: rtl/input_port_ctrl_if.sv
// Interface bundling the buffer-side, switch-control and crossbar-side
// signals of one router input port controller.
// Optional macro: PKT_COUNT_EN adds the pkt_count completed-packet counter.
//
// Handshake: a flit moves towards the crossbar in a cycle where tx (valid)
// and credit_i (ready) are both high at the rising clock edge; the same
// condition pops the buffer through fifo_pull. tx never waits on credit_i.
interface input_port_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    logic [WIDTH-1:0]         fifo_head;
    logic [$clog2(DEPTH):0]   fifo_counter;
    logic                     fifo_pull;
    logic                     h;
    logic                     ack_h;
    logic [WIDTH-1:0]         data_out;
    logic                     tx;
    logic                     credit_i;
    logic                     sender;
    // Debug visibility of the controller FSM and payload counter
    logic [2:0]               dbg_state;
    logic [WIDTH-1:0]         dbg_flit_cnt;
`ifdef PKT_COUNT_EN
    logic [15:0]              pkt_count;
`endif

`ifdef PKT_COUNT_EN
    modport master (
        input  fifo_head, fifo_counter, ack_h, credit_i,
        output fifo_pull, h, data_out, tx, sender, dbg_state, dbg_flit_cnt, pkt_count
    );
    modport slave (
        output fifo_head, fifo_counter, ack_h, credit_i,
        input  fifo_pull, h, data_out, tx, sender, dbg_state, dbg_flit_cnt, pkt_count
    );
`else
    modport master (
        input  fifo_head, fifo_counter, ack_h, credit_i,
        output fifo_pull, h, data_out, tx, sender, dbg_state, dbg_flit_cnt
    );
    modport slave (
        output fifo_head, fifo_counter, ack_h, credit_i,
        input  fifo_pull, h, data_out, tx, sender, dbg_state, dbg_flit_cnt
    );
`endif
endinterface

// File: rtl/input_port_ctrl.sv
// Input port packet controller: requests a route when a header sits at the
// buffer head, then streams header, size and payload flits to the crossbar
// under credit flow control, releasing the connection after the last flit.
// Optional macro: PKT_COUNT_EN adds a 16-bit wrapping completed-packet count.
module input_port_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    input_port_ctrl_if.master  port
);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        REQ          = 3'd1,
        SEND_HDR     = 3'd2,
        SEND_SIZE    = 3'd3,
        SEND_PAYLOAD = 3'd4
    } state_t;

    state_t           state_q;
    logic             h_q;
    logic             sender_q;
    logic [WIDTH-1:0] flit_cnt_q;
`ifdef PKT_COUNT_EN
    logic [15:0]      pkt_count_q;
`endif

    logic has_data;
    logic sending;
    logic tx;
    logic xfer;

    // tx is gated by reset so an aborted packet never pops the buffer
    assign has_data = (port.fifo_counter != '0);
    assign sending  = (state_q == SEND_HDR) || (state_q == SEND_SIZE) ||
                      (state_q == SEND_PAYLOAD);
    assign tx       = sending & has_data & ~reset;
    assign xfer     = tx & port.credit_i;

    assign port.tx           = tx;
    assign port.fifo_pull    = xfer;
    assign port.data_out     = port.fifo_head;
    assign port.h            = h_q;
    assign port.sender       = sender_q;
    assign port.dbg_state    = state_q;
    assign port.dbg_flit_cnt = flit_cnt_q;
`ifdef PKT_COUNT_EN
    assign port.pkt_count    = pkt_count_q;
`endif

    // Packet FSM: request, grant, then header/size/payload streaming
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            h_q        <= 1'b0;
            sender_q   <= 1'b0;
            flit_cnt_q <= '0;
`ifdef PKT_COUNT_EN
            pkt_count_q <= 16'd0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (has_data) begin
                        state_q <= REQ;
                        h_q     <= 1'b1;
                    end
                end
                REQ: begin
                    if (port.ack_h) begin
                        h_q      <= 1'b0;
                        sender_q <= 1'b1;
                        state_q  <= SEND_HDR;
                    end
                end
                SEND_HDR: begin
                    if (xfer) begin
                        state_q <= SEND_SIZE;
                    end
                end
                SEND_SIZE: begin
                    if (xfer) begin
                        flit_cnt_q <= port.fifo_head;
                        if (port.fifo_head == '0) begin
                            // zero-length packet ends on the size flit
                            sender_q <= 1'b0;
                            state_q  <= IDLE;
`ifdef PKT_COUNT_EN
                            pkt_count_q <= pkt_count_q + 16'd1;
`endif
                        end else begin
                            state_q <= SEND_PAYLOAD;
                        end
                    end
                end
                SEND_PAYLOAD: begin
                    // flit_cnt is at least 1 here, so the decrement never wraps
                    if (xfer) begin
                        flit_cnt_q <= flit_cnt_q - WIDTH'(1);
                        if (flit_cnt_q == WIDTH'(1)) begin
                            sender_q <= 1'b0;
                            state_q  <= IDLE;
`ifdef PKT_COUNT_EN
                            pkt_count_q <= pkt_count_q + 16'd1;
`endif
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_input_port_ctrl.sv
// Bench for input_port_ctrl: a queue-based buffer model feeds the DUT, the
// expected flit stream is queued as flits enter the buffer, and a negedge
// monitor checks every transfer plus packet boundaries against a
// packet-level model of the header/size/payload format.
module tb_input_port_ctrl;
    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clock = 1'b0;
    logic reset = 1'b1;

    // clock/reset block
    always #5 clock = ~clock;

    input_port_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) ifc ();
    input_port_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .port  (ifc)
    );

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] fq[$];
    logic [WIDTH-1:0] src_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    bit pull_seen = 1'b0;
    int pull_total = 0;
    int h_cnt = 0;
    bit ack_real = 1'b0;
    bit idle_pend = 1'b0;

    // packet-level model state used by the monitor
    int m_phase = 0;
    int m_left = 0;
    bit m_end = 1'b0;
    bit m_live = 1'b0;
    int m_pkts = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: checks output rules and scores every transfer
    always @(negedge clock) begin
        pull_seen = ifc.fifo_pull;
        if (ifc.fifo_pull) pull_total++;
        if (reset) begin
            chk("rst_pull", ifc.fifo_pull, 0);
            chk("rst_tx", ifc.tx, 0);
            m_phase = 0;
            m_end = 1'b0;
            m_live = 1'b0;
            m_pkts = 0;
        end else begin
            if (m_end) begin
                chk("end_sender", ifc.sender, 0);
`ifdef PKT_COUNT_EN
                chk("pkt_count", ifc.pkt_count, m_pkts);
`endif
                m_end = 1'b0;
            end else if (m_live) begin
                chk("mid_sender", ifc.sender, 1);
            end
            m_live = 1'b0;
            chk("data_out", ifc.data_out, ifc.fifo_head);
            chk("pull_rule", ifc.fifo_pull, ifc.tx & ifc.credit_i);
            chk("tx_rule", ifc.tx, ifc.sender & (ifc.fifo_counter != 0));
            if (ifc.tx && ifc.credit_i) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_xfer", 1, 0);
                end else begin
                    logic [WIDTH-1:0] e;
                    e = exp_q.pop_front();
                    chk("flit", ifc.data_out, e);
                    case (m_phase)
                        0: begin m_phase = 1; m_live = 1'b1; end
                        1: begin
                            if (e == 0) begin
                                m_phase = 0; m_end = 1'b1; m_pkts++;
                            end else begin
                                m_left = int'(e); m_phase = 2; m_live = 1'b1;
                            end
                        end
                        default: begin
                            m_left--;
                            if (m_left == 0) begin
                                m_phase = 0; m_end = 1'b1; m_pkts++;
                            end else begin
                                m_live = 1'b1;
                            end
                        end
                    endcase
                end
            end
        end
    end

    // driver: one clock of buffer model, credit and grant behaviour
    task automatic cycle(input int cmode, input int ack_delay, input bit rpush);
        int tries;
        @(posedge clock);
        #1;
        if (pull_seen && fq.size() > 0) void'(fq.pop_front());
        pull_seen = 1'b0;
        if (!reset) begin
            if (ack_real) chk("ack_to_tx", ifc.tx, 1);
            if (idle_pend) chk("h_latency", ifc.h, 1);
        end
        tries = rpush ? 1 : DEPTH;
        for (int k = 0; k < tries; k++) begin
            if (src_q.size() > 0 && fq.size() < DEPTH && (!rpush || $urandom_range(0, 2) == 0)) begin
                logic [WIDTH-1:0] f;
                f = src_q.pop_front();
                fq.push_back(f);
                exp_q.push_back(f);
            end
        end
        case (cmode)
            0: ifc.credit_i = 1'b1;
            1: ifc.credit_i = ~ifc.credit_i;
            default: ifc.credit_i = 1'($urandom_range(0, 1));
        endcase
        if (ifc.h) begin
            h_cnt++;
            ifc.ack_h = (h_cnt == ack_delay);
            ack_real = ifc.ack_h;
        end else begin
            h_cnt = 0;
            ack_real = 1'b0;
            ifc.ack_h = (cmode == 2) && ifc.sender && ($urandom_range(0, 3) == 0);
        end
        ifc.fifo_head = (fq.size() > 0) ? fq[0] : '0;
        ifc.fifo_counter = CW'(fq.size());
        idle_pend = !reset && !ifc.h && !ifc.sender && (fq.size() != 0);
    endtask

    task automatic run_until_idle(input int budget, input int cmode, input int ack_delay, input bit rpush);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            cycle(cmode, ack_delay, rpush);
            n++;
            done = (src_q.size() == 0) && (fq.size() == 0) && (exp_q.size() == 0) &&
                   !ifc.sender && !ifc.h;
        end
        chk("drain_done", done, 1);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        src_q.delete();
        fq.delete();
        exp_q.delete();
        ifc.ack_h = 1'b0;
        ifc.fifo_counter = '0;
        ifc.fifo_head = '0;
        h_cnt = 0;
        ack_real = 1'b0;
        idle_pend = 1'b0;
        repeat (n) @(posedge clock);
        #1;
        reset = 1'b0;
        pull_seen = 1'b0;
    endtask

    task automatic add_pkt(input logic [WIDTH-1:0] hdr, input int size);
        src_q.push_back(hdr);
        src_q.push_back(WIDTH'(size));
        for (int i = 0; i < size; i++) src_q.push_back(WIDTH'($urandom_range(0, 255)));
    endtask

    task automatic add_ref_pkt();
        src_q.push_back(8'h11);
        src_q.push_back(8'h02);
        src_q.push_back(8'hA1);
        src_q.push_back(8'hA2);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int p0;
        int n;
        ifc.fifo_head = '0;
        ifc.fifo_counter = '0;
        ifc.ack_h = 1'b0;
        ifc.credit_i = 1'b0;

        // reset, then an empty buffer for 10 cycles
        do_reset(3);
`ifdef PKT_COUNT_EN
        chk("pkt_count_rst", ifc.pkt_count, 0);
`endif
        for (int i = 0; i < 10; i++) begin
            cycle(0, 1, 1'b0);
            chk("idle_h", ifc.h, 0);
            chk("idle_sender", ifc.sender, 0);
            chk("idle_tx", ifc.tx, 0);
            chk("idle_pull", ifc.fifo_pull, 0);
        end

        // reference packet, grant three cycles after request, full credit
        p0 = pull_total;
        add_ref_pkt();
        run_until_idle(100, 0, 3, 1'b0);
        cycle(0, 1, 1'b0);
        chk("pulls_ref", pull_total - p0, 4);

        // same packet with alternating credit
        p0 = pull_total;
        add_ref_pkt();
        run_until_idle(100, 1, 2, 1'b0);
        cycle(0, 1, 1'b0);
        chk("pulls_credit", pull_total - p0, 4);

        // zero-length packet
        p0 = pull_total;
        add_pkt(8'h33, 0);
        run_until_idle(100, 0, 1, 1'b0);
        cycle(0, 1, 1'b0);
        chk("pulls_zero", pull_total - p0, 2);

        // back-to-back packets, request re-asserts from a non-empty buffer
        add_pkt(8'h44, 0);
        add_pkt(8'h55, 1);
        add_pkt(8'h66, 3);
        run_until_idle(200, 0, 1, 1'b0);

        // buffer runs dry before the last payload flit
        src_q.push_back(8'h11);
        src_q.push_back(8'h02);
        src_q.push_back(8'hA1);
        n = 0;
        while (!(exp_q.size() == 0 && fq.size() == 0 && ifc.sender) && n < 100) begin
            cycle(0, 2, 1'b0);
            n++;
        end
        chk("gap_reach", n < 100, 1);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 2, 1'b0);
            chk("gap_tx", ifc.tx, 0);
            chk("gap_cnt", ifc.dbg_flit_cnt, 1);
            chk("gap_sender", ifc.sender, 1);
        end
        src_q.push_back(8'hA2);
        run_until_idle(100, 0, 2, 1'b0);

        // reset in the middle of a payload with three flits left
        add_pkt(8'h77, 5);
        n = 0;
        while (!(exp_q.size() == 3 && ifc.sender) && n < 100) begin
            cycle(0, 1, 1'b0);
            n++;
        end
        chk("abort_reach", n < 100, 1);
        chk("abort_cnt", ifc.dbg_flit_cnt, 3);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("abort_h", ifc.h, 0);
        chk("abort_sender", ifc.sender, 0);
        chk("abort_cnt0", ifc.dbg_flit_cnt, 0);
        do_reset(1);

        // randomized packets, random push timing, credit and grant delay
        for (int b = 0; b < 5; b++) begin
            for (int p = 0; p < 5; p++) add_pkt(WIDTH'($urandom_range(0, 255)), $urandom_range(0, 6));
            run_until_idle(2000, 2, $urandom_range(1, 4), 1'b1);
        end

        repeat (3) cycle(0, 1, 1'b0);
        chk("leftover", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/input_port_ctrl.md
Name: input_port_ctrl

Overview:
- Per-input-port packet controller sitting directly downstream of fifo_buffer in each router input port.
- Watches the buffer head/occupancy and raises a routing request to switch control when a header flit is present.
- After the request is granted, streams header, size and payload flits from the buffer towards the crossbar under credit flow control, pulling the buffer one flit per transfer.
- Releases the connection after the last payload flit.

Parameters:
- WIDTH, `TAM_FLIT (8): flit width; also the width of the size field.
- DEPTH, `TAM_BUFFER (8): buffer depth; sets fifo_counter width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- fifo_head  in  WIDTH  head flit of the input buffer.
- fifo_counter  in  $clog2(DEPTH)+1  buffer occupancy.
- fifo_pull  out  1  pop one flit from the buffer.
- h  out  1  routing request to switch control.
- ack_h  in  1  routing grant from switch control.
- data_out  out  WIDTH  flit to crossbar; always equals fifo_head.
- tx  out  1  flit valid towards the crossbar.
- credit_i  in  1  downstream can accept a flit this cycle.
- sender  out  1  packet in progress; connection held while high.

Behaviour:
- Single clock domain, rising edge of clock.
- reset is synchronous and active-high; all state updates only on posedge clock.
- Reset values: state=IDLE, h=0, sender=0, flit_cnt=0; tx=0, fifo_pull=0 (combinational from state).
- Reset asserted mid-packet aborts immediately: no pull in the reset cycle, next state IDLE. The buffer is reset by the same signal.
- Transfer event: xfer = tx & credit_i. fifo_pull = xfer.
- tx = 1 only in SEND_HDR, SEND_SIZE and SEND_PAYLOAD, and only when fifo_counter != 0. An empty buffer stalls with no state change.
- FSM:
  - IDLE: if fifo_counter != 0, go to REQ and set h<=1. h rises the cycle after occupancy is seen.
  - REQ: hold h=1 until ack_h is sampled high, then h<=0, sender<=1, go to SEND_HDR. ack_h in any other state is ignored.
  - SEND_HDR: on xfer go to SEND_SIZE.
  - SEND_SIZE: on xfer, flit_cnt<=fifo_head.
    - If fifo_head==0: sender<=0, go to IDLE (zero-length packet).
    - Otherwise go to SEND_PAYLOAD.
  - SEND_PAYLOAD: on xfer, flit_cnt<=flit_cnt-1. If flit_cnt==1 at that xfer: sender<=0, go to IDLE.
- flit_cnt is WIDTH bits unsigned. Maximum payload is 2^WIDTH-1 flits; no wrap occurs because the counter is never decremented at 0.
- Latency:
  - Header first seen → h high: 1 cycle.
  - ack_h sampled → first tx possible: 1 cycle.
  - Sustained throughput: 1 flit/cycle while the buffer is non-empty and credit_i=1.
- Back-to-back packets: at least one IDLE cycle plus one REQ cycle between the last payload flit and the next header.
- credit_i low: tx stays high if data is available; no pull, no counter change.
- Simultaneous push into the buffer and pull by this block is legal; this block only observes fifo_counter.

Optional Feature:
- Macro: PKT_COUNT_EN.
- Defined: adds output pkt_count [15:0], reset to 0. It increments by 1 in the cycle sender falls (end of every packet, including zero-length) and wraps 16'hFFFF→0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
1. Reset, fifo_counter=0 for 10 cycles → h=0, tx=0, sender=0, fifo_pull=0 throughout.
2. Buffer holds 0x11, 0x02, 0xA1, 0xA2; ack_h given 3 cycles after h rises; credit_i=1 → data_out sequence 0x11, 0x02, 0xA1, 0xA2 on 4 consecutive xfers, exactly 4 pulls, sender falls the cycle after the 0xA2 transfer. With PKT_COUNT_EN, pkt_count=1.
3. Same packet, credit_i toggled 1,0,1,0 → tx held high, pulls only on credit_i=1 cycles, flit order unchanged, 4 pulls total.
4. Size flit 0x00 → only header and size transferred (2 pulls), then back to IDLE; h re-asserts if fifo_counter != 0.
5. Buffer empties after 0xA1 (fifo_counter=0 for 5 cycles), then 0xA2 is pushed → tx=0 during the gap, flit_cnt holds at 1, 0xA2 then completes the packet.
6. Reset asserted in SEND_PAYLOAD with flit_cnt=3 → next cycle state IDLE, h=0, sender=0, no pull in the reset cycle.
